// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: frame geometry, field offsets and controller states shared by pwm_frame_ctrl.
package pwm_ctrl_pkg;
    localparam int FRAME_BITS = 36;
    localparam int DUTY_W = 10;
    localparam int HDR_W = 6;
    localparam int HDR_LSB = 0;
    localparam int D0_LSB = HDR_LSB + HDR_W;
    localparam int D1_LSB = D0_LSB + DUTY_W;
    localparam int D2_LSB = D1_LSB + DUTY_W;
    typedef enum logic [1:0] {IDLE, RECV, PENDING} state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer followed by a registered rising-edge detector.
// EDGE=1 drives q with the one-cycle rise strobe, EDGE=0 with the level aligned to that strobe.
module sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input logic clk,
    input logic reset,
    input logic din,
    output logic q
);
    logic [1:0] sync;
    logic last;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync <= '0;
            last <= 1'b0;
            q <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            last <= sync[1];
            q <= EDGE ? (sync[1] & ~last) : sync[1];
        end
endmodule

// File: rtl/pwm_frame_ctrl.sv
// pwm_frame_ctrl: serial duty-frame receiver with shadow registers applied on PWM period boundaries,
// plus the shared prescaler and period counter. Define PWM_FRAME_PARITY_EN to make header bit 5 an even-parity bit.
module pwm_frame_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PRESCALE = 50,
    parameter logic [HDR_W-1:0] HDR_VAL = 6'h2A
) (
    input logic clk,
    input logic reset,
    input logic clock_data,
    input logic data,
    input logic frame_sync,
    output logic [DUTY_W-1:0] duty0,
    output logic [DUTY_W-1:0] duty1,
    output logic [DUTY_W-1:0] duty2,
    output logic [DUTY_W-1:0] pwm_cnt,
    output logic pwm_tick,
    output logic update,
    output logic frame_err,
    output logic pending
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [5:0] FULL = 6'(FRAME_BITS);
    logic cd_rise, fs_rise, data_s, hdr_ok, valid, boundary, apply, pend_nx, busy_nx;
    logic [PW-1:0] pre;
    logic [5:0] bitcnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [DUTY_W-1:0] sh0, sh1, sh2;
    state_t state;

    sync_edge #(.EDGE(1'b1)) u_cd (.clk(clk), .reset(reset), .din(clock_data), .q(cd_rise));
    sync_edge #(.EDGE(1'b0)) u_dt (.clk(clk), .reset(reset), .din(data), .q(data_s));
    sync_edge #(.EDGE(1'b1)) u_fs (.clk(clk), .reset(reset), .din(frame_sync), .q(fs_rise));

    assign pwm_tick = pre == PRE_MAX;
    assign boundary = pwm_tick && pwm_cnt == '1;
    assign apply = boundary && state == PENDING;
    assign pending = state == PENDING;
`ifdef PWM_FRAME_PARITY_EN
    assign hdr_ok = shreg[HDR_LSB +: HDR_W-1] == HDR_VAL[HDR_W-2:0]
                 && shreg[HDR_LSB+HDR_W-1] == ^shreg[FRAME_BITS-1:D0_LSB];
`else
    assign hdr_ok = shreg[HDR_LSB +: HDR_W] == HDR_VAL;
`endif
    assign valid = fs_rise && bitcnt == FULL && hdr_ok;

    // A valid commit always (re)arms pending, even on the boundary cycle that drains the old shadow.
    always_comb begin
        pend_nx = valid || (pending && !apply);
        busy_nx = !fs_rise && (bitcnt != '0 || cd_rise);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            pre <= '0;
            pwm_cnt <= '0;
            bitcnt <= '0;
            shreg <= '0;
            {sh0, sh1, sh2} <= '0;
            {duty0, duty1, duty2} <= '0;
            update <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pre <= pwm_tick ? '0 : pre + PW'(1);
            pwm_cnt <= pwm_cnt + DUTY_W'(pwm_tick);
            update <= apply;
            frame_err <= fs_rise && !valid;
            state <= pend_nx ? PENDING : busy_nx ? RECV : IDLE;
            if (apply) begin
                duty0 <= sh0;
                duty1 <= sh1;
                duty2 <= sh2;
            end
            if (valid) begin
                sh0 <= shreg[D0_LSB +: DUTY_W];
                sh1 <= shreg[D1_LSB +: DUTY_W];
                sh2 <= shreg[D2_LSB +: DUTY_W];
            end
            // A commit wins over a bit arriving in the same cycle; that bit is dropped.
            if (fs_rise) bitcnt <= '0;
            else if (cd_rise) begin
                if (bitcnt < FULL) shreg[bitcnt] <= data_s;
                if (bitcnt <= FULL) bitcnt <= bitcnt + 6'd1;
            end
        end
endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// tb_pwm_frame_ctrl: randomized serial frames checked against a cycle-count reference model of pwm_frame_ctrl.
module tb_pwm_frame_ctrl;
    localparam int P = 3;
    localparam int N = 1024 * P;
    localparam logic [5:0] HDR = 6'h2A;

    logic clk = 1'b0, reset = 1'b1, clock_data = 1'b0, data = 1'b0, frame_sync = 1'b0;
    logic [9:0] duty0, duty1, duty2, pwm_cnt;
    logic pwm_tick, update, frame_err, pending;
    int vectors = 0, errors = 0;
    int cyc = 0, upd_cnt = 0, last_upd = -1;
    logic [9:0] upd_pc = '0;
    logic [9:0] m_duty[3], m_shadow[3];
    bit m_pend = 1'b0;
    int m_upd_at = 0;

    pwm_frame_ctrl #(.PRESCALE(P), .HDR_VAL(HDR)) dut (
        .clk(clk), .reset(reset), .clock_data(clock_data), .data(data), .frame_sync(frame_sync),
        .duty0(duty0), .duty1(duty1), .duty2(duty2), .pwm_cnt(pwm_cnt),
        .pwm_tick(pwm_tick), .update(update), .frame_err(frame_err), .pending(pending)
    );

    always #5 clk = ~clk;

    // cyc = clock edges since reset release; update pulses are logged with the cycle they appear in
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
    always @(negedge clk)
        if (!reset && update) begin
            upd_cnt <= upd_cnt + 1;
            last_upd <= cyc;
            upd_pc <= pwm_cnt;
        end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [9:0] rnd();
        return 10'($urandom_range(1, 1023));
    endfunction

    function automatic logic [39:0] mk(input logic [9:0] d0, input logic [9:0] d1, input logic [9:0] d2,
                                      input logic [5:0] h, input bit flip);
        logic [39:0] f;
        f = {4'b0, d2, d1, d0, h};
`ifdef PWM_FRAME_PARITY_EN
        f[5] = (^f[35:6]) ^ flip;
`else
        f[5] = f[5] ^ flip;
`endif
        return f;
    endfunction

    function automatic bit ref_valid(input logic [39:0] f, input int n);
`ifdef PWM_FRAME_PARITY_EN
        return n == 36 && f[4:0] == HDR[4:0] && f[5] == ^f[35:6];
`else
        return n == 36 && f[5:0] == HDR;
`endif
    endfunction

    task automatic model_clear;
        m_duty = '{default: '0};
        m_shadow = '{default: '0};
        m_pend = 1'b0;
    endtask

    // commit at cycle c: drain a due shadow first, then a valid frame waits for the first boundary after c
    task automatic model_commit(input logic [39:0] f, input int n, input int c);
        if (m_pend && c >= m_upd_at) begin
            m_duty = m_shadow;
            m_pend = 1'b0;
        end
        if (ref_valid(f, n)) begin
            m_shadow = '{f[15:6], f[25:16], f[35:26]};
            if (!m_pend) m_upd_at = (c / N + 1) * N;
            m_pend = 1'b1;
        end
    endtask

    task automatic shift(input logic [39:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            data = f[i];
            clock_data = 1'b0;
            repeat (4) @(negedge clk);
            clock_data = 1'b1;
            repeat (4) @(negedge clk);
        end
        clock_data = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // returns at the negedge of the cycle in which the commit has taken effect
    task automatic send(input logic [39:0] f, input int n, input int fs_at, output int c);
        shift(f, n);
        while (cyc < fs_at) @(negedge clk);
        frame_sync = 1'b1;
        c = cyc + 4;
        repeat (4) @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic await_update(input int base, output bit ok, output int at);
        ok = 1'b0;
        for (int i = 0; i < 2 * N + 16 && !ok; i++) begin
            @(negedge clk);
            ok = upd_cnt != base;
        end
        at = last_upd;
        if (m_pend) begin
            m_duty = m_shadow;
            m_pend = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({duty0, duty1, duty2, pwm_cnt, pwm_tick, update, frame_err, pending} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got duty=%0d/%0d/%0d cnt=%0d tick=%b upd=%b err=%b pend=%b, need all 0",
                     duty0, duty1, duty2, pwm_cnt, pwm_tick, update, frame_err, pending);
        end
        vectors++;
        if (dut.bitcnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_bitcnt: got %0d, need 0", dut.bitcnt);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_counter;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            if (i == 20) while (cyc % N != N - 3) @(negedge clk);
            vectors++;
            if (pwm_cnt !== 10'((cyc / P) % 1024) || pwm_tick !== (cyc % P == P - 1)) begin
                errors++;
                $display("FAIL counter: cyc=%0d got cnt=%0d tick=%b, need cnt=%0d tick=%b",
                         cyc, pwm_cnt, pwm_tick, (cyc / P) % 1024, cyc % P == P - 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_valid;
        logic [39:0] f;
        int c, base, at;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            f = k == 0 ? mk(10'd100, 10'd512, 10'd1023, HDR, 1'b0) : mk(rnd(), rnd(), rnd(), HDR, 1'b0);
            base = upd_cnt;
            send(f, 36, 0, c);
            model_commit(f, 36, c);
            vectors++;
            if (frame_err !== 1'b0 || pending !== 1'b1) begin
                errors++;
                $display("FAIL valid_commit: got err=%b pend=%b, need err=0 pend=1", frame_err, pending);
            end
            c = m_upd_at;
            await_update(base, ok, at);
            vectors++;
            if (!ok || at != c || upd_pc !== 10'd0 || pending !== 1'b0
                || {duty0, duty1, duty2} !== {m_duty[0], m_duty[1], m_duty[2]}) begin
                errors++;
                $display("FAIL valid_apply: got seen=%b at=%0d cnt=%0d pend=%b duty=%0d/%0d/%0d, need at=%0d cnt=0 pend=0 duty=%0d/%0d/%0d",
                         ok, at, upd_pc, pending, duty0, duty1, duty2, c, m_duty[0], m_duty[1], m_duty[2]);
            end
        end
    endtask

    task automatic test_bad_len;
        logic [39:0] f;
        int c;
        for (int k = 0; k < 2; k++) begin
            f = mk(rnd(), rnd(), rnd(), HDR, 1'b0);
            f[36] = 1'($urandom_range(0, 1));
            send(f, k == 0 ? 35 : 37, 0, c);
            model_commit(f, k == 0 ? 35 : 37, c);
            vectors++;
            if (frame_err !== 1'b1 || pending !== 1'b0 || {duty0, duty1, duty2} !== {m_duty[0], m_duty[1], m_duty[2]}) begin
                errors++;
                $display("FAIL bad_len_%0d: got err=%b pend=%b duty=%0d/%0d/%0d, need err=1 pend=0 duty=%0d/%0d/%0d",
                         35 + 2 * k, frame_err, pending, duty0, duty1, duty2, m_duty[0], m_duty[1], m_duty[2]);
            end
            vectors++;
            if (dut.bitcnt !== 6'd0) begin
                errors++;
                $display("FAIL bad_len_bitcnt: got %0d, need 0", dut.bitcnt);
            end
            @(negedge clk);
            vectors++;
            if (frame_err !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse_width: got err=%b one cycle later, need 0", frame_err);
            end
        end
    endtask

    task automatic test_bad_hdr;
        logic [39:0] f;
        int c;
        for (int k = 0; k < 2; k++) begin
            f = k == 0 ? mk(rnd(), rnd(), rnd(), 6'h15, 1'b0) : mk(rnd(), rnd(), rnd(), HDR, 1'b1);
            send(f, 36, 0, c);
            model_commit(f, 36, c);
            vectors++;
            if (frame_err !== 1'b1 || pending !== 1'b0 || {duty0, duty1, duty2} !== {m_duty[0], m_duty[1], m_duty[2]}) begin
                errors++;
                $display("FAIL bad_hdr_%0d: got err=%b pend=%b duty=%0d/%0d/%0d, need err=1 pend=0 duty=%0d/%0d/%0d",
                         k, frame_err, pending, duty0, duty1, duty2, m_duty[0], m_duty[1], m_duty[2]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [39:0] f;
        logic [9:0] d0;
        int c, base, at, nf;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            while (cyc % N != 16) @(negedge clk);
            base = upd_cnt;
            nf = k == 0 ? 2 : int'($urandom_range(2, 3));
            for (int j = 0; j < nf; j++) begin
                d0 = k == 0 ? (j == 0 ? 10'd10 : 10'd20) : rnd();
                f = mk(d0, rnd(), rnd(), HDR, 1'b0);
                send(f, 36, 0, c);
                model_commit(f, 36, c);
                vectors++;
                if (frame_err !== 1'b0 || pending !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_commit: got err=%b pend=%b, need err=0 pend=1", frame_err, pending);
                end
            end
            c = m_upd_at;
            await_update(base, ok, at);
            repeat (8) @(negedge clk);
            vectors++;
            if (!ok || at != c || upd_cnt != base + 1 || {duty0, duty1, duty2} !== {m_duty[0], m_duty[1], m_duty[2]}) begin
                errors++;
                $display("FAIL b2b_apply: got at=%0d updates=%0d duty=%0d/%0d/%0d, need at=%0d updates=1 duty=%0d/%0d/%0d",
                         at, upd_cnt - base, duty0, duty1, duty2, c, m_duty[0], m_duty[1], m_duty[2]);
            end
            if (k == 0) begin
                vectors++;
                if (duty0 !== 10'd20) begin
                    errors++;
                    $display("FAIL latest_wins: got duty0=%0d, need 20", duty0);
                end
            end
        end
    endtask

    task automatic test_boundary_commit;
        logic [39:0] f;
        int c, base, at, m, exp_at;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            m = (cyc / N + 1) * N;
            if (m - cyc < 400) m += N;
            f = mk(rnd(), rnd(), rnd(), HDR, 1'b0);
            base = upd_cnt;
            send(f, 36, m - 4 - k, c);
            model_commit(f, 36, c);
            exp_at = k == 0 ? m + N : m;
            vectors++;
            if (update !== 1'b0 || pending !== 1'b1 || c != m - k) begin
                errors++;
                $display("FAIL boundary_commit_%0d: got upd=%b pend=%b commit=%0d, need upd=0 pend=1 commit=%0d",
                         k, update, pending, c, m - k);
            end
            await_update(base, ok, at);
            vectors++;
            if (!ok || at != exp_at || {duty0, duty1, duty2} !== {m_duty[0], m_duty[1], m_duty[2]}) begin
                errors++;
                $display("FAIL boundary_apply_%0d: got seen=%b at=%0d duty=%0d/%0d/%0d, need at=%0d duty=%0d/%0d/%0d",
                         k, ok, at, duty0, duty1, duty2, exp_at, m_duty[0], m_duty[1], m_duty[2]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [39:0] f;
        int c, base, at;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            f = mk(rnd(), rnd(), rnd(), HDR, 1'b0);
            if (k == 0) shift(f, 20);
            else begin
                send(f, 36, 0, c);
                model_commit(f, 36, c);
                vectors++;
                if (pending !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_pre_pend: got pend=%b, need 1", pending);
                end
            end
            #3 reset = 1'b1;
            #1;
            vectors++;
            if ({duty0, duty1, duty2, pwm_cnt, pwm_tick, update, frame_err, pending} !== '0 || dut.bitcnt !== 6'd0) begin
                errors++;
                $display("FAIL reset_mid_%0d: got duty=%0d/%0d/%0d cnt=%0d pend=%b bitcnt=%0d, need all 0",
                         k, duty0, duty1, duty2, pwm_cnt, pending, dut.bitcnt);
            end
            @(negedge clk);
            clock_data = 1'b0;
            data = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            model_clear();
        end
        f = mk(rnd(), rnd(), rnd(), HDR, 1'b0);
        base = upd_cnt;
        send(f, 36, 0, c);
        model_commit(f, 36, c);
        c = m_upd_at;
        await_update(base, ok, at);
        vectors++;
        if (!ok || at != c || {duty0, duty1, duty2} !== {m_duty[0], m_duty[1], m_duty[2]}) begin
            errors++;
            $display("FAIL reset_recover: got seen=%b at=%0d duty=%0d/%0d/%0d, need at=%0d duty=%0d/%0d/%0d",
                     ok, at, duty0, duty1, duty2, c, m_duty[0], m_duty[1], m_duty[2]);
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_valid();
        test_bad_len();
        test_bad_hdr();
        test_back_to_back();
        test_boundary_commit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
